// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 pipelined bus bundle; master drives the request, slave the response.
interface wb_if #(
  parameter int ADR_W  = 32,
  parameter int DATA_W = 32
);

  logic                cyc;
  logic                stb;
  logic                we;
  logic [ADR_W-1:0]    adr;
  logic [DATA_W/8-1:0] sel;
  logic [DATA_W-1:0]   dat_o;
  logic [DATA_W-1:0]   dat_i;
  logic                ack;
  logic                err;
  logic                stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_o,
    input  dat_i, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_o,
    output dat_i, ack, err, stall
  );

endinterface

// File: rtl/wb_arbiter2.sv
// Round-robin arbiter of two Wishbone masters onto one slave, holding ownership
// for a whole cyc burst and throttling once MAX_OUTSTANDING requests are unanswered.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic clk,
  input  logic rst_n,
  wb_if.slave  m0,
  wb_if.slave  m1,
  wb_if.master s
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic          last;
  logic [CW-1:0] cnt;

  logic gnt0;
  logic gnt1;
  logic full;
  logic rls;
  logic accept;
  logic dec;

  assign gnt0   = (state == GNT0);
  assign gnt1   = (state == GNT1);
  assign full   = (cnt == CNT_MAX);
  assign rls    = (gnt0 & ~m0.cyc) | (gnt1 & ~m1.cyc);
  assign accept = s.stb & ~s.stall;
  // A response with nothing outstanding is forwarded but must not underflow.
  assign dec    = (s.ack | s.err) & (cnt != '0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (m0.cyc && m1.cyc) state_nxt = last ? GNT0 : GNT1;
        else if (m0.cyc)      state_nxt = GNT0;
        else if (m1.cyc)      state_nxt = GNT1;
      end
      GNT0:    if (!m0.cyc) state_nxt = IDLE;
      GNT1:    if (!m1.cyc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == GNT0) last <= 1'b0;
      if (state == IDLE && state_nxt == GNT1) last <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (rls) begin
      cnt <= '0;
    end else begin
      unique case ({accept, dec})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Request path: granted master straight through, stb held off while full.
  always_comb begin
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.adr   = '0;
    s.sel   = '0;
    s.dat_o = '0;
    if (gnt0) begin
      s.cyc   = m0.cyc;
      s.stb   = m0.stb & ~full;
      s.we    = m0.we;
      s.adr   = m0.adr;
      s.sel   = m0.sel;
      s.dat_o = m0.dat_o;
    end else if (gnt1) begin
      s.cyc   = m1.cyc;
      s.stb   = m1.stb & ~full;
      s.we    = m1.we;
      s.adr   = m1.adr;
      s.sel   = m1.sel;
      s.dat_o = m1.dat_o;
    end
  end

  assign m0.dat_i = s.dat_i;
  assign m0.ack   = gnt0 & s.ack;
  assign m0.err   = gnt0 & s.err;
  assign m0.stall = gnt0 ? (s.stall | full) : 1'b1;

  assign m1.dat_i = s.dat_i;
  assign m1.ack   = gnt1 & s.ack;
  assign m1.err   = gnt1 & s.err;
  assign m1.stall = gnt1 ? (s.stall | full) : 1'b1;

endmodule
